// File: rtl/karatsuba_combine_if.sv
// Handshake/data bundle for karatsuba_combine: partial-product input side and product output side.
interface karatsuba_combine_if #(
  parameter int unsigned N_BITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*N_BITS-1:0]   z0;
  logic [2*N_BITS-1:0]   z2;
  logic [2*N_BITS+1:0]   zm;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*N_BITS-1:0]   p;
  logic                  err;

  modport slave (
    input  in_valid, z0, z2, zm, out_ready,
    output in_ready, out_valid, p, err
  );

  modport master (
    output in_valid, z0, z2, zm, out_ready,
    input  in_ready, out_valid, p, err
  );
endinterface

// File: rtl/karatsuba_combine.sv
// Two-stage Karatsuba recombination: mid = zm - z0 - z2, then p = z2<<2N + mid<<N + z0.
// Define KARATSUBA_COMBINE_CHECK_EN to build the sticky middle-term underflow flag on err.
module karatsuba_combine #(
  parameter int unsigned N_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  karatsuba_combine_if.slave    bus
);
  localparam int unsigned W  = 2 * N_BITS;
  localparam int unsigned MW = W + 2;
  localparam int unsigned PW = 4 * N_BITS;

  logic          s1_valid_q, s1_valid_d;
  logic [W:0]    mid_q, mid_d;
  logic [W-1:0]  z0_q, z0_d;
  logic [W-1:0]  z2_q, z2_d;
  logic          s2_valid_q, s2_valid_d;
  logic [PW-1:0] p_q, p_d;

  logic          s1_adv, s2_adv, accept;
  logic [MW-1:0] mid_full;

`ifdef KARATSUBA_COMBINE_CHECK_EN
  logic          err_q, err_d;
`endif

  always_comb begin
    s2_adv     = !s2_valid_q || bus.out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    accept     = bus.in_valid && s1_adv;
    mid_full   = bus.zm - MW'(bus.z0) - MW'(bus.z2);

    s1_valid_d = s1_valid_q;
    mid_d      = mid_q;
    z0_d       = z0_q;
    z2_d       = z2_q;
    s2_valid_d = s2_valid_q;
    p_d        = p_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
    end
    if (accept) begin
      mid_d = mid_full[W:0];
      z0_d  = bus.z0;
      z2_d  = bus.z2;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        p_d = (PW'(z2_q) << W) + (PW'(mid_q) << N_BITS) + PW'(z0_q);
      end
    end

`ifdef KARATSUBA_COMBINE_CHECK_EN
    // Top bit of the widened subtraction is the borrow: zm < z0 + z2.
    err_d = err_q || (accept && mid_full[MW-1]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      mid_q      <= '0;
      z0_q       <= '0;
      z2_q       <= '0;
      s2_valid_q <= 1'b0;
      p_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      mid_q      <= mid_d;
      z0_q       <= z0_d;
      z2_q       <= z2_d;
      s2_valid_q <= s2_valid_d;
      p_q        <= p_d;
    end
  end

`ifdef KARATSUBA_COMBINE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_borrow;
  assign unused_borrow = mid_full[MW-1];
  assign bus.err       = 1'b0;
`endif

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.p         = p_q;
endmodule
